// File: rtl/mac_ctrl_pkg.sv
// Shared definitions for the MAC array control path.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package mac_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WFETCH  = 3'd1,
        ST_WDRAIN  = 3'd2,
        ST_WLOAD   = 3'd3,
        ST_COMPUTE = 3'd4,
        ST_FLUSH   = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    localparam int KSZ_W = 4;
    localparam int KK_W  = 2 * KSZ_W;

    // Square at double width so K=15 yields 225 rather than a truncated value.
    function automatic logic [KK_W-1:0] kk_of(input logic [KSZ_W-1:0] k);
        logic [KK_W-1:0] kw;
        kw = {{KSZ_W{1'b0}}, k};
        return kw * kw;
    endfunction

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth shift register for a single valid strobe, with synchronous clear.
// Latency: DEPTH cycles from din to dout.
// Backpressure: none; clr discards every bit in flight.
module valid_delay_line #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else if (clr) begin
            sr <= '0;
        end else begin
            sr[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/mac_array_sequencer.sv
// Sequences weight fetch, weight load and ifmap streaming for one MAC array job.
// Latency: K*K+3 cycles to first ifmap issue; done 2+PSUM_LAT cycles after the last issue.
// Backpressure: stalls ifmap issue while ifmaps_fifo_empty is high; start ignored while busy.
module mac_array_sequencer
    import mac_ctrl_pkg::*;
#(
    parameter int MAC_NUM            = 256,
    parameter int KMAX               = 5,
    parameter int BRAM_ADDRESS_WIDTH = 12,
    parameter int PIX_W              = 16,
    parameter int PSUM_LAT           = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          abort,
    input  logic [KSZ_W-1:0]              kernel_size,
    input  logic [BRAM_ADDRESS_WIDTH-1:0] weight_base,
    input  logic [PIX_W-1:0]              num_pix,
    input  logic [MAC_NUM-1:0]            lane_en,
    output logic [BRAM_ADDRESS_WIDTH-1:0] bram_addr,
    output logic                          bram_rd_en,
    output logic                          load_weight_preload,
    output logic                          load_MAC_weight,
    input  logic                          ifmaps_fifo_empty,
    output logic                          ifmaps_fifo_rd,
    output logic                          load_ifmaps,
    output logic [MAC_NUM-1:0]            enable,
    output logic                          psum_valid,
    output logic                          busy,
    output logic                          done,
    output logic                          error
);

    localparam logic [BRAM_ADDRESS_WIDTH-1:0] ADDR_ONE = 1;
    localparam logic [KK_W-1:0]               KK_ONE   = 1;
    localparam logic [PIX_W-1:0]              PIX_ONE  = 1;
    localparam logic [KSZ_W-1:0]              KMAX_K   = KSZ_W'(KMAX);
    localparam logic [KK_W-1:0]               LAT_LAST = KK_W'(PSUM_LAT - 1);

    state_t           state;
    logic [KK_W-1:0]  kk_lat;
    logic [KK_W-1:0]  cnt;
    logic [PIX_W-1:0] pix_lat;
    logic [PIX_W-1:0] issued;
    logic             job_ok;
    logic             abort_hit;
    logic             issue;

    assign job_ok    = (kernel_size != '0) && (kernel_size <= KMAX_K) && (num_pix != '0);
    assign abort_hit = abort && (state != ST_IDLE);

    // Issue must track the FIFO flag in the same cycle, so it is decoded rather than registered.
    assign issue          = (state == ST_COMPUTE) && !abort && !ifmaps_fifo_empty && (issued != pix_lat);
    assign ifmaps_fifo_rd = issue;
    assign load_ifmaps    = issue;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= ST_IDLE;
            kk_lat              <= '0;
            cnt                 <= '0;
            pix_lat             <= '0;
            issued              <= '0;
            bram_addr           <= '0;
            bram_rd_en          <= 1'b0;
            load_weight_preload <= 1'b0;
            load_MAC_weight     <= 1'b0;
            enable              <= '0;
            busy                <= 1'b0;
            done                <= 1'b0;
            error               <= 1'b0;
        end else begin
            error               <= 1'b0;
            done                <= 1'b0;
            load_MAC_weight     <= 1'b0;
            load_weight_preload <= bram_rd_en;
            if (abort_hit) begin
                state               <= ST_IDLE;
                cnt                 <= '0;
                issued              <= '0;
                bram_addr           <= '0;
                bram_rd_en          <= 1'b0;
                load_weight_preload <= 1'b0;
                enable              <= '0;
                busy                <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            if (job_ok) begin
                                kk_lat     <= kk_of(kernel_size);
                                pix_lat    <= num_pix;
                                enable     <= lane_en;
                                bram_addr  <= weight_base;
                                bram_rd_en <= 1'b1;
                                busy       <= 1'b1;
                                cnt        <= '0;
                                state      <= ST_WFETCH;
                            end else begin
                                error <= 1'b1;
                            end
                        end
                    end
                    ST_WFETCH: begin
                        if (cnt == kk_lat - KK_ONE) begin
                            bram_rd_en <= 1'b0;
                            cnt        <= '0;
                            state      <= ST_WDRAIN;
                        end else begin
                            cnt       <= cnt + KK_ONE;
                            bram_addr <= bram_addr + ADDR_ONE;
                        end
                    end
                    ST_WDRAIN: begin
                        load_MAC_weight <= 1'b1;
                        state           <= ST_WLOAD;
                    end
                    ST_WLOAD: begin
                        issued <= '0;
                        state  <= ST_COMPUTE;
                    end
                    ST_COMPUTE: begin
                        if (issued == pix_lat) begin
                            cnt   <= '0;
                            state <= ST_FLUSH;
                        end else if (issue) begin
                            issued <= issued + PIX_ONE;
                        end
                    end
                    ST_FLUSH: begin
                        if (cnt == LAT_LAST) begin
                            cnt   <= '0;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            cnt <= cnt + KK_ONE;
                        end
                    end
                    ST_DONE: begin
                        issued <= '0;
                        enable <= '0;
                        busy   <= 1'b0;
                        state  <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    valid_delay_line #(
        .DEPTH (PSUM_LAT)
    ) u_psum_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (abort_hit),
        .din   (load_ifmaps),
        .dout  (psum_valid)
    );

endmodule
